// File: rtl/forwarding_scoreboard_pkg.sv
// rtl/forwarding_scoreboard_pkg.sv - shared constants and helpers for the forwarding scoreboard
// Purpose: bit layout of a downstream shadow-pipeline entry, the register-file
//          bypass encoding and a constant clog2 used for derived widths.
// Ports:   none (package)
package forwarding_scoreboard_pkg;

  // Downstream stage entry, packed LSB first: {rd, load, wen, valid}
  localparam int ENT_VALID = 0;
  localparam int ENT_WEN   = 1;
  localparam int ENT_LOAD  = 2;
  localparam int ENT_RD    = 3;
  localparam int ENT_FLAGS = 3;

  // fwd_sel value meaning "read the register file"
  localparam int FWD_SEL_RF = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-source nearest-producer bypass comparator
// Purpose: picks the lowest-numbered downstream stage whose live destination
//          tag equals this source address; 0 when none or when disabled.
// Ports:   enable   - EX valid and this source actually read
//          rs       - source register address
//          tag_live - per stage: entry may forward (valid, writes, rd != 0, not a load in stage 1)
//          tag_rd   - per stage destination address, stage k at [(k-1)*REG_AW +: REG_AW]
//          sel      - bypass select, 0 = register file, k = stage k
module fwd_match
  import forwarding_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = clog2(FWD_STAGES + 1)
) (
  input  logic                         enable,
  input  logic [REG_AW-1:0]            rs,
  input  logic [FWD_STAGES-1:0]        tag_live,
  input  logic [FWD_STAGES*REG_AW-1:0] tag_rd,
  output logic [SEL_W-1:0]             sel
);

  // Walk from the oldest stage to the youngest so the nearest match overwrites.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    if (enable && (rs != '0)) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (tag_live[k-1] && (tag_rd[(k-1)*REG_AW +: REG_AW] == rs)) begin
          sel = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - forwarding and hazard controller for the pipelined core
// Purpose: tracks destination tags of the EX instruction and FWD_STAGES downstream
//          stages, produces per-source bypass selects, and stalls/holds/bubbles the
//          ID/EX boundary for load-use hazards and multi-cycle multiplies.
// Ports:   clk, arst_n           - clock, asynchronous active-low reset
//          id_*                   - instruction currently in ID
//          flush                  - branch redirect, kills ID and EX
//          fwd_sel                - per-source bypass select for EX, SEL_W bits each
//          stall_id/hold_ex       - hold PC+IF/ID, hold ID/EX
//          bubble_ex              - a bubble enters EX at the next edge
//          mul_busy               - multiply occupying EX
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MUL_LAT    = 3,
  parameter int SEL_W      = clog2(FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_load,
  input  logic                      id_mul,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic                      hold_ex,
  output logic                      bubble_ex,
  output logic                      mul_busy
);

  localparam int ENT_W = ENT_FLAGS + REG_AW;
  localparam int CNT_W = (MUL_LAT > 1) ? clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  logic                      ex_valid, ex_wen, ex_load, ex_mul;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic [FWD_STAGES-1:0][ENT_W-1:0] pipe_q;   // index 0 is stage 1
  logic [CNT_W-1:0]          mul_cnt;

  logic [ENT_W-1:0]             ex_ent;
  logic [FWD_STAGES-1:0]        tag_live;
  logic [FWD_STAGES*REG_AW-1:0] tag_rd;
  logic                         src_hit, load_use;

  always_comb begin
    ex_ent                    = '0;
    ex_ent[ENT_VALID]         = ex_valid;
    ex_ent[ENT_WEN]           = ex_wen;
    ex_ent[ENT_LOAD]          = ex_load;
    ex_ent[ENT_RD +: REG_AW]  = ex_rd;
  end

  // A load sitting in stage 1 never forwards: its data is not ready yet and
  // the load-use stall already keeps dependents out of EX for that cycle.
  always_comb begin
    tag_live = '0;
    tag_rd   = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      tag_rd[k*REG_AW +: REG_AW] = pipe_q[k][ENT_RD +: REG_AW];
      tag_live[k] = pipe_q[k][ENT_VALID] && pipe_q[k][ENT_WEN]
                    && (pipe_q[k][ENT_RD +: REG_AW] != '0)
                    && !((k == 0) && pipe_q[k][ENT_LOAD]);
    end
  end

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) src_hit = 1'b1;
    end
    load_use = id_valid && ex_valid && ex_wen && ex_load && (ex_rd != '0) && src_hit;
  end

  assign mul_busy  = ex_valid && ex_mul && (mul_cnt != '0);
  // Reset gates the combinational controls so they read 0 while arst_n is low.
  assign stall_id  = arst_n && !flush && (mul_busy || load_use);
  assign hold_ex   = arst_n && !flush && mul_busy;
  assign bubble_ex = arst_n && (flush || (!mul_busy && (load_use || !id_valid)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_valid   <= 1'b0;
      ex_wen     <= 1'b0;
      ex_load    <= 1'b0;
      ex_mul     <= 1'b0;
      ex_rd      <= '0;
      ex_rs      <= '0;
      ex_rs_used <= '0;
      pipe_q     <= '0;
      mul_cnt    <= '0;
    end else begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        pipe_q[k] <= pipe_q[k-1];
      end
      if (flush) begin
        ex_valid  <= 1'b0;
        mul_cnt   <= '0;
        pipe_q[0] <= '0;
      end else if (mul_busy) begin
        pipe_q[0] <= '0;
        mul_cnt   <= mul_cnt - CNT_W'(1);
      end else if (load_use) begin
        pipe_q[0] <= ex_ent;
        ex_valid  <= 1'b0;
      end else begin
        pipe_q[0]  <= ex_ent;
        ex_valid   <= id_valid;
        ex_wen     <= id_regwrite;
        ex_load    <= id_load;
        ex_mul     <= id_mul;
        ex_rd      <= id_rd;
        ex_rs      <= id_rs;
        ex_rs_used <= id_rs_used;
        mul_cnt    <= (id_valid && id_mul) ? MUL_LOAD : '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .REG_AW    (REG_AW),
      .FWD_STAGES(FWD_STAGES),
      .SEL_W     (SEL_W)
    ) u_match (
      .enable  (ex_valid && ex_rs_used[i]),
      .rs      (ex_rs[i*REG_AW +: REG_AW]),
      .tag_live(tag_live),
      .tag_rd  (tag_rd),
      .sel     (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - scoreboard bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

  localparam int S_FWD = 0, S_STALL = 1, S_HOLD = 2, S_BUB = 3, S_BUSY = 4, S_FWD3 = 5;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       id_valid = 0, id_regwrite = 0, id_load = 0, id_mul = 0, flush = 0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_rs_used = '0;
  logic [4:0] id_rd = '0;
  logic [3:0] fwd_sel;
  logic       stall_id, hold_ex, bubble_ex, mul_busy;

  // FWD_STAGES=3, NUM_SRC=3 instance
  logic        id3_valid = 0, id3_regwrite = 0, id3_load = 0, id3_mul = 0, flush3 = 0;
  logic [14:0] id3_rs = '0;
  logic [2:0]  id3_rs_used = '0;
  logic [4:0]  id3_rd = '0;
  logic [5:0]  fwd_sel3;
  logic        stall3, hold3, bubble3, busy3;

  forwarding_scoreboard u_dut (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load), .id_mul(id_mul), .flush(flush),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .hold_ex(hold_ex), .bubble_ex(bubble_ex),
    .mul_busy(mul_busy)
  );

  forwarding_scoreboard #(.REG_AW(5), .NUM_SRC(3), .FWD_STAGES(3), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .arst_n(arst_n), .id_valid(id3_valid), .id_rs(id3_rs), .id_rs_used(id3_rs_used),
    .id_rd(id3_rd), .id_regwrite(id3_regwrite), .id_load(id3_load), .id_mul(id3_mul),
    .flush(flush3), .fwd_sel(fwd_sel3), .stall_id(stall3), .hold_ex(hold3),
    .bubble_ex(bubble3), .mul_busy(busy3)
  );

  typedef struct {
    string name;
    int    sig;
    int    exp;
    int    tcyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    int v;
    case (sig)
      S_FWD:   v = fwd_sel;
      S_STALL: v = stall_id;
      S_HOLD:  v = hold_ex;
      S_BUB:   v = bubble_ex;
      S_BUSY:  v = mul_busy;
      default: v = fwd_sel3;
    endcase
    return v;
  endfunction

  task automatic expect_now(input string name, input int sig, input int val);
    exp_t e;
    e.name = name; e.sig = sig; e.exp = val; e.tcyc = cyc;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation tagged with the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tcyc <= cyc) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      n_checks++;
      a = actual(e.sig);
      if (e.tcyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.tcyc, cyc);
      end else if (a != e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, a, e.exp, cyc);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r0,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic mul);
    id_valid = v; id_rs = {r1, r0}; id_rs_used = used; id_rd = rd;
    id_regwrite = wen; id_load = ld; id_mul = mul;
  endtask

  task automatic set_id3(input logic v, input logic [14:0] rs, input logic [2:0] used,
                         input logic [4:0] rd, input logic wen);
    id3_valid = v; id3_rs = rs; id3_rs_used = used; id3_rd = rd; id3_regwrite = wen;
  endtask

  initial begin
    // reset state
    step;
    expect_now("rst_fwd", S_FWD, 0);
    expect_now("rst_fwd3", S_FWD3, 0);
    expect_now("rst_stall", S_STALL, 0);
    expect_now("rst_hold", S_HOLD, 0);
    expect_now("rst_bubble", S_BUB, 0);
    expect_now("rst_busy", S_BUSY, 0);
    @(negedge clk); #1;
    arst_n = 1'b1;
    set_id(1, 0, 0, 2'b00, 5, 1, 0, 0);                   // add x5

    // nearest producer wins
    step; set_id(1, 0, 0, 2'b00, 5, 1, 0, 0);             // E1: sub x5 in ID
    expect_now("e1_bubble", S_BUB, 0);
    expect_now("e1_stall", S_STALL, 0);
    step; set_id(1, 5, 5, 2'b11, 6, 1, 0, 0);             // E2: consumer of x5
    step; set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);             // E3: consumer in EX
    expect_now("nearest_fwd", S_FWD, 5);
    expect_now("idle_bubble", S_BUB, 1);

    // load-use
    step; set_id(1, 0, 1, 2'b01, 7, 1, 1, 0);             // E4: lw x7 in ID
    expect_now("bubble_in_ex_fwd", S_FWD, 0);
    step; set_id(1, 0, 7, 2'b01, 8, 1, 0, 0);             // E5: lw in EX, reader in ID
    expect_now("lu_stall", S_STALL, 1);
    expect_now("lu_bubble", S_BUB, 1);
    expect_now("lu_hold", S_HOLD, 0);
    step;                                                  // E6: bubble in EX
    expect_now("lu_after_stall", S_STALL, 0);
    expect_now("lu_after_bubble", S_BUB, 0);
    expect_now("lu_after_fwd", S_FWD, 0);
    step; set_id(1, 0, 0, 2'b00, 3, 1, 0, 0);             // E7: reader in EX, add x3 in ID
    expect_now("lu_fwd_stage2", S_FWD, 2);

    // x0 never forwarded, unused source never forwarded
    step; set_id(1, 0, 0, 2'b00, 0, 1, 0, 0);             // E8: addi x0 in ID
    step; set_id(1, 3, 0, 2'b01, 0, 0, 0, 0);             // E9: reads x0, x3 unused
    step; set_id(1, 0, 1, 2'b01, 7, 1, 1, 0);             // E10: lw x7 in ID
    expect_now("x0_unused_fwd", S_FWD, 0);

    // flush wins over load-use
    step; set_id(1, 0, 7, 2'b01, 8, 1, 0, 0); flush = 1;  // E11
    expect_now("flush_lu_stall", S_STALL, 0);
    expect_now("flush_lu_bubble", S_BUB, 1);
    step; flush = 0; set_id(1, 0, 0, 2'b00, 10, 1, 0, 1); // E12: mul x10 in ID
    expect_now("post_flush_fwd", S_FWD, 0);
    expect_now("post_flush_stall", S_STALL, 0);

    // multiply hold, MUL_LAT=3 -> two busy cycles
    step; set_id(1, 0, 10, 2'b01, 11, 1, 0, 0);           // E13
    expect_now("mul_busy_c1", S_BUSY, 1);
    expect_now("mul_stall_c1", S_STALL, 1);
    expect_now("mul_hold_c1", S_HOLD, 1);
    expect_now("mul_bubble_c1", S_BUB, 0);
    step;                                                  // E14
    expect_now("mul_busy_c2", S_BUSY, 1);
    expect_now("mul_stall_c2", S_STALL, 1);
    expect_now("mul_hold_c2", S_HOLD, 1);
    step;                                                  // E15
    expect_now("mul_busy_c3", S_BUSY, 0);
    expect_now("mul_stall_c3", S_STALL, 0);
    expect_now("mul_hold_c3", S_HOLD, 0);
    step; set_id(1, 0, 0, 2'b00, 12, 1, 0, 1);            // E16: dependent in EX
    expect_now("mul_dep_fwd", S_FWD, 1);

    // flush on the first busy cycle
    step; set_id(1, 0, 12, 2'b01, 13, 1, 0, 0); flush = 1; // E17
    expect_now("fl_mul_busy_now", S_BUSY, 1);
    expect_now("fl_mul_stall", S_STALL, 0);
    expect_now("fl_mul_hold", S_HOLD, 0);
    expect_now("fl_mul_bubble", S_BUB, 1);
    step; flush = 0; set_id(1, 0, 0, 2'b00, 13, 1, 0, 1); // E18: mul x13 in ID
    expect_now("fl_mul_busy_after", S_BUSY, 0);
    expect_now("fl_mul_fwd", S_FWD, 0);
    expect_now("fl_mul_stall_after", S_STALL, 0);
    expect_now("fl_mul_bubble_after", S_BUB, 0);

    // asynchronous reset in the middle of a multiply
    step; set_id(1, 0, 13, 2'b01, 14, 1, 0, 0);           // E19: mul busy
    #1 arst_n = 1'b0;
    expect_now("arst_busy", S_BUSY, 0);
    expect_now("arst_stall", S_STALL, 0);
    expect_now("arst_hold", S_HOLD, 0);
    expect_now("arst_bubble", S_BUB, 0);
    expect_now("arst_fwd", S_FWD, 0);
    expect_now("arst_fwd3", S_FWD3, 0);
    @(negedge clk); #1;
    arst_n = 1'b1;
    set_id(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step;                                                  // E20: empty pipeline
    expect_now("post_rst_busy", S_BUSY, 0);
    expect_now("post_rst_stall", S_STALL, 0);
    expect_now("post_rst_bubble", S_BUB, 1);
    expect_now("post_rst_fwd", S_FWD, 0);

    // FWD_STAGES=3, NUM_SRC=3: producer only in stage 3
    set_id3(1, '0, 3'b000, 4, 1);                         // add x4
    step; set_id3(1, '0, 3'b000, 0, 0);                   // nop
    step; set_id3(1, '0, 3'b000, 0, 0);                   // nop
    step; set_id3(1, {5'd4, 5'd4, 5'd4}, 3'b101, 9, 1);   // reads x4 on src 0,2
    step; set_id3(0, '0, 3'b000, 0, 0);
    expect_now("p3_stage3_fwd", S_FWD3, 51);              // {3,0,3}
    step;
    expect_now("p3_empty_fwd", S_FWD3, 0);

    step; step;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

- Parametrised forwarding and hazard controller for the pipelined core.
- Keeps its own shadow pipeline of destination-register tags for the instruction in EX and for FWD_STAGES downstream stages.
- For each EX source operand it outputs a nearest-producer-wins bypass select.
- Detects load-use hazards and multi-cycle multiply occupancy, and drives stall, hold and bubble controls to the ID/EX boundary.

## Interface
Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and never forwarded
- NUM_SRC, 2, source operands per instruction
- FWD_STAGES, 2, downstream stages able to forward (1 = EX/MEM, 2 = MEM/WB, …); minimum 1
- MUL_LAT, 3, EX occupancy in cycles of a multiply; minimum 1
- SEL_W, $clog2(FWD_STAGES+1), derived select width

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - arst_n  in  1  reset
- ID-stage instruction:
  - id_valid  in  1  ID holds a real instruction
  - id_rs  in  NUM_SRC*REG_AW  source addresses, source i at [i*REG_AW +: REG_AW]
  - id_rs_used  in  NUM_SRC  source i is actually read
  - id_rd  in  REG_AW  destination
  - id_regwrite  in  1  writes id_rd
  - id_load  in  1  is a load
  - id_mul  in  1  is a multiply
- flush  in  1  branch redirect; kill ID and EX contents
- Outputs:
  - fwd_sel  out  NUM_SRC*SEL_W  per-source bypass select for the EX instruction; 0 = register file, k = stage k
  - stall_id  out  1  hold PC and IF/ID
  - hold_ex  out  1  hold ID/EX (multiply busy)
  - bubble_ex  out  1  a bubble enters EX this cycle
  - mul_busy  out  1  multiply occupying EX

## Operation
**Shadow state**
- EX entry: {valid, rd, wen, load, mul, rs[NUM_SRC], rs_used}.
- pipe[1..FWD_STAGES], each entry: {valid, rd, wen, load}.
- A bubble is valid=0.

**Per-cycle priority**
1. flush:
   - EX entry becomes a bubble.
   - Multiply counter clears.
   - pipe shifts normally: pipe[1] <= bubble, pipe[k+1] <= pipe[k].
   - stall_id=0.
2. mul_busy, i.e. counter ≠ 0:
   - EX entry held.
   - pipe[1] <= bubble; higher stages shift.
   - stall_id=1, hold_ex=1.
   - Counter decrements.
3. load-use hazard, when all of:
   - id_valid
   - EX valid & wen & load & rd ≠ 0
   - some i with id_rs_used[i] and id_rs[i] == EX.rd

   Then:
   - pipe[1] <= EX.
   - EX <= bubble.
   - stall_id=1, bubble_ex=1.
4. Normal advance:
   - pipe[1] <= EX, pipe[k+1] <= pipe[k].
   - EX <= ID fields if id_valid, else bubble.
   - bubble_ex = !id_valid.

**Multiply counter**
- When a valid multiply enters EX, the counter loads MUL_LAT-1.
- MUL_LAT=1 never asserts mul_busy.

**fwd_sel[i]**
- Combinational from registered shadow state only; no ID inputs in the path.
- If EX.valid & EX.rs_used[i] & EX.rs[i] ≠ 0:
  - select the smallest k with pipe[k].valid & pipe[k].wen & pipe[k].rd == EX.rs[i];
  - otherwise 0.
- A load in pipe[1] is excluded from matching; the load-use stall guarantees such a match cannot be required.
- Writes to rd=0 never match.

## Timing
- Reset values:
  - all valid bits 0, counter 0;
  - fwd_sel=0, stall_id=0, hold_ex=0, bubble_ex=0, mul_busy=0.
- stall_id, hold_ex, bubble_ex:
  - combinational from current shadow state plus ID inputs;
  - apply at the next rising edge.
- fwd_sel is valid in the same cycle the instruction occupies EX, zero added latency.
- Load-use costs exactly 1 bubble. A multiply costs MUL_LAT-1 stall cycles.
- Simultaneous events:
  - flush with load-use or mul_busy: flush wins.
  - mul_busy with load-use cannot both apply, because EX cannot be both load and multiply.
- Reset mid-multiply aborts immediately; the first post-reset cycle behaves as an empty pipeline.

## Structure
- Shared package/header holds:
  - the stage-entry field layout constants;
  - the FWD_SEL_RF=0 encoding;
  - the clog2 helper.
- One sub-module: fwd_match.
  - Per-source priority comparator over FWD_STAGES tags.
  - Instantiated NUM_SRC times via generate.

## Test plan
- **Nearest producer wins:** `add x5` then `sub x5`, then a consumer of x5 enters EX → fwd_sel = 1, not 2.
- **Load-use stall:** `lw x7` in EX, ID reads x7 →
  - stall_id=1 and bubble_ex=1 for one cycle;
  - next cycle consumer in EX has fwd_sel = 2.
- **x0 never forwarded:** producer `addi x0` in pipe[1], consumer reads x0 → fwd_sel = 0. Unused source matching any rd → 0.
- **Multiply hold:** MUL_LAT=3, multiply enters EX →
  - mul_busy, stall_id, hold_ex high for exactly 2 cycles;
  - pipe[1] receives 2 bubbles;
  - a dependent in ID then advances.
- **Flush during multiply:** flush on the 1st busy cycle →
  - mul_busy=0 next cycle;
  - EX empty;
  - fwd_sel=0.
- **Parameter sweep:** FWD_STAGES=3, NUM_SRC=3, producer in stage 3 only → select 3 for each matching source. Also check async reset asserted mid-sequence clears all outputs without a clock edge.
